// File: rtl/obi_sram_responder.sv
// OBI subordinate terminating one core-side port in a word-addressed, byte-writable SRAM.
// Optional write-protect input (wprot_i) is compiled in when OBI_SRAM_WPROT_EN is defined.
module obi_sram_responder #(
  parameter int unsigned NumWords   = 1024,
  parameter logic [31:0] BaseAddr   = 32'h1000_0000,
  parameter int unsigned WaitCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
`ifdef OBI_SRAM_WPROT_EN
  input  logic        wprot_i,
`endif
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW      = $clog2(NumWords);
  localparam logic [31:0] SpanBytes = 32'(NumWords * 4);
  localparam logic [3:0]  WaitLoad  = 4'(WaitCycles);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        rd_sel_q, rd_sel_d;
  logic [31:0] rdata_word;

  logic [31:0]     offset;
  logic            hit;
  logic [IdxW-1:0] word_idx;
  logic            gnt;
  logic            wprot;
  logic            mem_we;
  logic            mem_re;

  // Unsigned wrap-around makes addresses below BaseAddr miss as well.
  assign offset   = addr_i - BaseAddr;
  assign hit      = offset < SpanBytes;
  assign word_idx = offset[IdxW+1:2];

`ifdef OBI_SRAM_WPROT_EN
  assign wprot = wprot_i;
`else
  assign wprot = 1'b0;
`endif

  assign gnt    = (state_q == ST_IDLE) && req_i;
  assign gnt_o  = gnt;
  assign mem_we = gnt && !rst_i && we_i && hit && !wprot;
  assign mem_re = gnt && !rst_i && !we_i && hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    rd_sel_d = rd_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          err_d    = !hit || (we_i && wprot);
          rd_sel_d = !we_i && hit;
          if (WaitCycles == 0) begin
            rvalid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // One byte lane per array; the lane output register doubles as the response data hold.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [NumWords];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk_i) begin
      if (mem_re) begin
        lane_rd_q <= lane_mem[word_idx];
      end
      if (mem_we && be_i[gi]) begin
        lane_mem[word_idx] <= wdata_i[8*gi +: 8];
      end
    end

    assign rdata_word[8*gi +: 8] = lane_rd_q;
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = rvalid_q && err_q;
  assign rdata_o  = (rvalid_q && rd_sel_q) ? rdata_word : 32'h0;

endmodule

// File: doc/obi_sram_responder.md
Name: obi_sram_responder

Overview:
- OBI subordinate (responder) terminating one core-side OBI port (instruction or data) in a word-addressed, byte-writable on-chip memory array.
- Sits between the crossbar/core and local SRAM.
- Grants requests, performs reads/writes, and returns exactly one rvalid pulse per granted request, with configurable latency and an address-range error.
- No rready: the initiator must always accept rvalid.

Parameters:
- NumWords, 1024, memory depth in 32-bit words; power of two, >= 2.
- BaseAddr, 32'h1000_0000, byte base address of the array; aligned to NumWords*4.
- WaitCycles, 0, extra cycles between grant and rvalid (0..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  request valid.
- gnt_o  out  1  request granted this cycle.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes; ignored for reads.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one-cycle pulse.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  response error, qualified by rvalid_o.

Behaviour:
- Reset:
  - Applied while rst_i=1 at a clock edge.
  - Afterwards: rvalid_o=0, err_o=0, rdata_o=0, wait counter=0, FSM=IDLE.
  - Memory contents are not reset.
  - A pending request during reset is dropped; no rvalid is ever issued for it.
- FSM:
  - IDLE: gnt_o = req_i (combinational). On a grant:
    - WaitCycles=0: stay IDLE.
    - Otherwise: load counter=WaitCycles and go to WAIT.
  - WAIT: gnt_o=0. Counter decrements each cycle. When counter reaches 1, go to IDLE the next cycle.
- Latency:
  - Grant in cycle N -> rvalid_o=1 in cycle N+1+WaitCycles, for exactly one cycle.
  - Back-to-back: with WaitCycles=0, a grant is possible every cycle, and the rvalid for request k coincides with the grant of request k+1.
  - A new grant is possible in the same cycle as the previous rvalid.
  - At most one request is outstanding beyond the current grant cycle.
- Address decode:
  - hit = (addr_i - BaseAddr) < NumWords*4, evaluated as unsigned 32-bit.
  - Word index = (addr_i - BaseAddr)[log2(NumWords)+1:2].
  - Miss: no array access. The response carries err_o=1 and rdata_o=0, for both reads and writes.
- Write (hit):
  - Array updated at the grant edge; byte i written iff be_i[i].
  - be_i=0: no change; response still issued with err_o=0.
  - Response: rdata_o=0, err_o=0.
- Read (hit):
  - Array sampled at the grant edge, so it returns data prior to any write granted in the same cycle.
  - A write granted at N followed by a read of the same word at N+1 returns the new data.
  - Data is held in a response register until rvalid_o.
  - rdata_o is 0 whenever rvalid_o=0.
- Response capture: we, hit and read data are captured at grant. Input changes after grant have no effect.
- A req_i deasserted without a grant is legal; no state change.

Optional Feature:
- Macro: OBI_SRAM_WPROT_EN.
- Defined:
  - Adds port wprot_i (in, 1), sampled at grant.
  - A write granted while wprot_i=1 does not modify the array and responds with err_o=1, rdata_o=0.
  - Reads are unaffected.
  - A write miss still reports err_o=1 (single error bit).
- Undefined: port absent; writes behave as above.

Test Plan:
- Reset with WaitCycles=0: hold rst_i=1 for 2 cycles with req_i=1 -> gnt_o may assert, but rvalid_o=0, rdata_o=0 and err_o=0 through the cycle after reset release. No response ever appears for that request.
- Byte write then read, WaitCycles=0:
  - Write 0x1000_0010, be=4'hF, data 0xDEADBEEF; then write be=4'b0101, data 0x11223344; then read.
  - Expect rvalid one cycle after each grant. Read returns 0xDE22BE44, err=0.
- Back-to-back, WaitCycles=0:
  - 8 consecutive reads with req_i held -> gnt_o high for 8 consecutive cycles.
  - 8 rvalid pulses offset by 1 cycle, in order, with correct data.
- Latency, WaitCycles=3: read granted at cycle 10 -> gnt_o=0 at cycles 11..13; rvalid_o at cycle 14; next grant possible at cycle 14.
- Out-of-range:
  - Read at 0x0FFF_FFFC -> rvalid, err_o=1, rdata_o=0.
  - Write at BaseAddr+NumWords*4 -> err_o=1; array unchanged (read back of word 0 and the last word is unmodified).
- Reset mid-operation, WaitCycles=5: grant at cycle 20, rst_i=1 at cycle 22 -> no rvalid at cycle 26. The first post-reset request is granted in its first cycle. With OBI_SRAM_WPROT_EN, also: write with wprot_i=1 -> err_o=1, and a subsequent read returns the old data.
